// File: rtl/fb_pkg.sv
// Shared constants, state type and slot helper for the framebuffer loader.
package fb_pkg;

  localparam int unsigned IMG_W      = 460;
  localparam int unsigned IMG_H      = 460;
  localparam int unsigned IMG_PIXELS = IMG_W * IMG_H;
  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned DATA_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } fb_state_t;

  // First RAM address of the selected image slot.
  function automatic int unsigned slot_base(input logic sel,
                                            input int unsigned pixels = IMG_PIXELS);
    return sel ? pixels : 0;
  endfunction

endpackage

// File: rtl/fb_loader_if.sv
// Pixel stream handshake plus RAM port B write bus.
//   in_valid/in_data : upstream pixel stream into the loader
//   in_ready         : loader accepts a pixel this cycle
//   wr_address/wr_data/wren : RAM port B write
// slave = loader side, master = stream source / RAM side.
interface fb_loader_if #(
  parameter int unsigned AW = fb_pkg::ADDR_W,
  parameter int unsigned DW = fb_pkg::DATA_W
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] wr_data;
  logic          wren;

  modport slave  (input  in_valid, in_data,
                  output in_ready, wr_address, wr_data, wren);
  modport master (output in_valid, in_data,
                  input  in_ready, wr_address, wr_data, wren);
endinterface

// File: rtl/fb_addr_gen.sv
// Write pointer plus row/col tracking for end-of-image detection.
//   load       : restart at base with row=col=0 (wins over advance)
//   advance    : one pixel written, step pointer and position
//   ptr        : address for the next pixel
//   last_pixel_c : current position is the final pixel of the image
module fb_addr_gen import fb_pkg::*; #(
  parameter int unsigned COLS = IMG_W,
  parameter int unsigned ROWS = IMG_H,
  parameter int unsigned AW   = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic          advance,
  output logic [AW-1:0] ptr,
  output logic          last_pixel_c
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [AW-1:0]    ptr_d, ptr_q;
  logic [COL_W-1:0] col_d, col_q;
  logic [ROW_W-1:0] row_d, row_q;
  logic             col_last_c;

  assign col_last_c   = (col_q == COL_W'(COLS - 1));
  assign last_pixel_c = col_last_c && (row_q == ROW_W'(ROWS - 1));
  assign ptr          = ptr_q;

  // Running pointer; row/col only locate the end of the image.
  always_comb begin
    ptr_d = ptr_q;
    col_d = col_q;
    row_d = row_q;
    if (load) begin
      ptr_d = base;
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      ptr_d = ptr_q + AW'(1);
      if (col_last_c) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/fb_loader.sv
// Framebuffer writer: streams one image into RAM port B, slot 0 or 1.
//   clk, rst     : clock, async active-high reset
//   start        : begin a load (IDLE only); img_sel picks the slot
//   abort        : cancel a load in progress
//   bus          : pixel stream in, RAM port B write out
//   busy         : high while loading
//   done         : one-cycle pulse after the final pixel write
module fb_loader import fb_pkg::*; #(
  parameter int unsigned COLS = IMG_W,
  parameter int unsigned ROWS = IMG_H,
  parameter int unsigned AW   = ADDR_W,
  parameter int unsigned DW   = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         img_sel,
  input  logic         abort,
  fb_loader_if.slave   bus,
  output logic         busy,
  output logic         done
);

  localparam int unsigned PIXELS = COLS * ROWS;

  fb_state_t     state_d, state_q;
  logic          in_ready_d, in_ready_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;
  logic          wren_d, wren_q;
  logic [AW-1:0] wr_address_d, wr_address_q;
  logic [DW-1:0] wr_data_d, wr_data_q;

  logic          xfer_c, load_c, advance_c, last_pixel_c;
  logic [AW-1:0] ptr;
  logic [AW-1:0] base_c;

  assign xfer_c = bus.in_valid & in_ready_q;
  assign base_c = AW'(slot_base(img_sel, PIXELS));

  fb_addr_gen #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .load         (load_c),
    .base         (base_c),
    .advance      (advance_c),
    .ptr          (ptr),
    .last_pixel_c (last_pixel_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    wren_d       = 1'b0;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    load_c       = 1'b0;
    advance_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        if (start) begin
          load_c     = 1'b1;
          state_d    = LOAD;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      LOAD: begin
        // Abort discards a same-cycle transfer.
        if (abort) begin
          state_d    = IDLE;
          in_ready_d = 1'b0;
          busy_d     = 1'b0;
        end else if (xfer_c) begin
          wren_d       = 1'b1;
          wr_address_d = ptr;
          wr_data_d    = bus.in_data;
          advance_c    = 1'b1;
          if (last_pixel_c) begin
            state_d    = DONE;
            in_ready_d = 1'b0;
            busy_d     = 1'b0;
          end
        end
      end
      DONE: begin
        done_d     = 1'b1;
        state_d    = IDLE;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wren_q       <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wren_q       <= wren_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.wr_address = wr_address_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wren       = wren_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_fb_loader.sv
// Bench for fb_loader, run on a reduced 20x12 image so full loads stay short.
module tb_fb_loader;
  import fb_pkg::*;

  localparam int unsigned COLS = 20;
  localparam int unsigned ROWS = 12;
  localparam int unsigned PIX  = COLS * ROWS;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic start   = 1'b0;
  logic img_sel = 1'b0;
  logic abort   = 1'b0;
  logic busy, done;

  fb_loader_if #(.AW(ADDR_W), .DW(DATA_W)) bus ();

  fb_loader #(.COLS(COLS), .ROWS(ROWS), .AW(ADDR_W), .DW(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .img_sel (img_sel),
    .abort   (abort),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is a count of pixels from a slot base.
  bit        m_loading   = 1'b0;
  bit        m_finishing = 1'b0;
  int        m_base      = 0;
  int        m_n         = 0;
  bit        e_wren      = 1'b0;
  bit        e_done      = 1'b0;
  int        e_addr      = 0;
  logic [7:0] e_data     = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading = 1'b0; m_finishing = 1'b0; m_base = 0; m_n = 0;
      e_wren = 1'b0; e_done = 1'b0; e_addr = 0; e_data = 8'h00;
    end else begin
      e_wren = 1'b0;
      e_done = 1'b0;
      if (m_finishing) begin
        e_done      = 1'b1;
        m_finishing = 1'b0;
      end else if (m_loading) begin
        if (abort) begin
          m_loading = 1'b0;
        end else if (bus.in_valid) begin
          e_wren = 1'b1;
          e_addr = m_base + m_n;
          e_data = bus.in_data;
          m_n++;
          if (m_n == PIX) begin
            m_loading   = 1'b0;
            m_finishing = 1'b1;
          end
        end
      end else if (start) begin
        m_base    = img_sel ? PIX : 0;
        m_n       = 0;
        m_loading = 1'b1;
      end
    end
  end

  // Observed write statistics for literal checks.
  int         wr_cnt     = 0;
  int         done_cnt   = 0;
  bit         seen_first = 1'b0;
  int         first_addr = 0;
  int         last_addr  = 0;
  logic [7:0] last_data  = 8'h00;

  always @(negedge clk) begin
    check("wren",       32'(bus.wren),       32'(e_wren));
    check("done",       32'(done),           32'(e_done));
    check("in_ready",   32'(bus.in_ready),   32'(m_loading));
    check("busy",       32'(busy),           32'(m_loading));
    check("wr_address", 32'(bus.wr_address), 32'(e_addr));
    check("wr_data",    32'(bus.wr_data),    32'(e_data));
    if (bus.wren === 1'b1) begin
      wr_cnt++;
      last_addr = int'(bus.wr_address);
      last_data = bus.wr_data;
      if (!seen_first) begin
        seen_first = 1'b1;
        first_addr = int'(bus.wr_address);
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  int pix_sent = 0;
  bit data_inc = 1'b0;

  task automatic drive(input bit v, input bit st, input bit sel, input bit ab);
    @(negedge clk);
    start        = st;
    img_sel      = sel;
    abort        = ab;
    bus.in_valid = v;
    bus.in_data  = data_inc ? 8'(pix_sent) : 8'($urandom);
    if (v && bus.in_ready === 1'b1) pix_sent++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_stats();
    wr_cnt = 0; done_cnt = 0; seen_first = 1'b0; first_addr = 0; last_addr = 0;
  endtask

  task automatic start_load(input bit sel);
    clear_stats();
    pix_sent = 0;
    drive(1'b0, 1'b1, sel, 1'b0);
  endtask

  task automatic stream_to(input int target, input int gap_pct);
    int budget;
    budget = 4 * target + 100;
    while (pix_sent < target && budget > 0) begin
      drive(($urandom_range(99) >= 32'(gap_pct)), 1'b0, 1'b0, 1'b0);
      budget--;
    end
    if (pix_sent < target) begin
      total++;
      bad++;
      $display("FAIL stream_timeout actual=%0d required=%0d", pix_sent, target);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_wren", 32'(bus.wren), 32'd0);
    check("reset_addr", 32'(bus.wr_address), 32'd0);
    rst = 1'b0;
    idle(2);

    // Full slot-0 load, no gaps, data = address low byte.
    data_inc = 1'b1;
    start_load(1'b0);
    stream_to(PIX, 0);
    idle(4);
    check("s0_count", 32'(wr_cnt), 32'(PIX));
    check("s0_first", 32'(first_addr), 32'd0);
    check("s0_last",  32'(last_addr), 32'(PIX - 1));
    check("s0_data",  32'(last_data), 32'(8'(PIX - 1)));
    check("s0_done",  32'(done_cnt), 32'd1);
    data_inc = 1'b0;

    // Slot-1 load with gaps and an ignored start at pixel 100.
    start_load(1'b1);
    stream_to(100, 30);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_addr", 32'(bus.wr_address), 32'(PIX + 100));
    stream_to(PIX, 30);
    idle(4);
    check("s1_count", 32'(wr_cnt), 32'(PIX));
    check("s1_first", 32'(first_addr), 32'(PIX));
    check("s1_last",  32'(last_addr), 32'(2 * PIX - 1));
    check("s1_done",  32'(done_cnt), 32'd1);

    // Abort coinciding with a transfer at pixel 50.
    start_load(1'b1);
    stream_to(50, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("abort_count", 32'(wr_cnt), 32'd50);
    check("abort_last",  32'(last_addr), 32'(PIX + 49));
    check("abort_done",  32'(done_cnt), 32'd0);

    // Restart on slot 0, then reset at row 1 col 0.
    start_load(1'b0);
    stream_to(COLS + 1, 0);
    @(posedge clk);
    #1;
    check("pre_rst_wren", 32'(bus.wren), 32'd1);
    check("pre_rst_addr", 32'(bus.wr_address), 32'(COLS));
    check("restart_first", 32'(first_addr), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("rst_wren",     32'(bus.wren), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_addr",     32'(bus.wr_address), 32'd0);
    check("rst_data",     32'(bus.wr_data), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    start_load(1'b0);
    stream_to(5, 0);
    idle(3);
    check("post_rst_first", 32'(first_addr), 32'd0);
    check("post_rst_count", 32'(wr_cnt), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
